fsm_arbiter: RTL
================

FSM_ARBITER -- requirements
Module: fsm_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; legal values 2..8.
REQ-002 Parameter MAX_HOLD, default 16: maximum cycles one grant may be held; legal values 2..255.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 req  input  N_REQ  one request bit per requester, level-sensitive.
REQ-006 done  input  N_REQ  per-requester end-of-use indication, sampled only for the granted requester.
REQ-007 gnt  output  N_REQ  registered one-hot grant, or all-zero.
REQ-008 gnt_id  output  $clog2(N_REQ)  binary index of the current or last grantee.
REQ-009 busy  output  1  high while in state GRANT.
REQ-010 timeout  output  1  one-cycle pulse when a grant is revoked by the watchdog.

Function
REQ-011 The FSM shall have exactly three states: IDLE, GRANT and RELEASE.
REQ-012 In IDLE, when req is non-zero at a rising edge, the FSM shall go to GRANT, load gnt/gnt_id with the round-robin winner, and clear hold_cnt.
- gnt is therefore high from the next cycle.
REQ-013 In IDLE with req all-zero, the FSM shall stay in IDLE.
REQ-014 Round-robin: the winner is the first set req bit scanning upward from last_id+1, wrapping from N_REQ-1 to 0.
REQ-015 In GRANT, done[gnt_id]=1 or req[gnt_id]=0 shall move the FSM to RELEASE at the next edge.
REQ-016 In GRANT, done and req bits of non-granted requesters shall be ignored.
REQ-017 Otherwise in GRANT, hold_cnt shall increment by 1 each cycle, saturating at MAX_HOLD-1.
REQ-018 Entering RELEASE shall clear gnt to zero, set last_id to gnt_id, and hold gnt_id unchanged.
REQ-019 RELEASE shall last exactly one cycle and then return to IDLE.
- Minimum grant-to-grant gap: 2 cycles (RELEASE + IDLE).
REQ-020 If done and a re-request from the same requester coincide, that requester shall lose priority to every other pending requester in the next arbitration.
REQ-021 busy shall equal (state==GRANT).
REQ-022 gnt shall never have more than one bit set.

Reset
REQ-023 While rst=0, asynchronously:
- state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, hold_cnt=0
- last_id=N_REQ-1, so requester 0 has first priority.
REQ-024 Reset asserted mid-grant shall drop gnt in the same cycle, without waiting for a clock edge.
REQ-025 After rst deasserts, the first arbitration shall follow REQ-012 with no extra wait cycles.

Configuration
REQ-026 Macro FSM_ARBITER_TIMEOUT_EN defined:
- In GRANT, when hold_cnt==MAX_HOLD-1 and no release condition holds, the FSM shall go to RELEASE and pulse timeout for exactly one cycle (the RELEASE cycle).
- A release condition in that same cycle takes precedence, and timeout stays 0.
REQ-027 Macro undefined:
- No watchdog; the grant is held until done or req drops.
- timeout shall be tied to 0.
- hold_cnt logic may be omitted.

Structure
REQ-028 Shared package fsm_arb_pkg shall hold:
- the state typedef (IDLE=2'b00, GRANT=2'b01, RELEASE=2'b10)
- default constants for N_REQ and MAX_HOLD.
REQ-029 The round-robin selection shall be a separate combinational sub-module, rr_pick: inputs req and last_id; outputs winner index and valid.
REQ-030 Implementation shall have one sequential always block for the state, grant and counter registers, and separate combinational blocks for next-state and output logic.

Verification
REQ-031 Single requester, N_REQ=4:
- req=4'b0100 held, done[2] pulsed 3 cycles after gnt rises.
- Expect gnt=4'b0100 one cycle after req, then RELEASE, then gnt=0, last_id=2.
REQ-032 All requesting, req=4'b1111, each grant released by done after 1 cycle:
- Expect grant order 0,1,2,3,0.
- Expect each grant separated by exactly 2 cycles of gnt=0.
REQ-033 Wrap and fairness, last_id=3, req=4'b1001:
- Expect gnt=4'b0001.
- After done with req[0] still high, expect gnt=4'b1000 next.
REQ-034 Requester abandons, req[1] drops during GRANT without done:
- Expect RELEASE at the next edge, timeout=0.
REQ-035 Watchdog, macro defined, MAX_HOLD=4, req[0] held, no done:
- Expect busy high 4 cycles, then RELEASE with timeout=1 for 1 cycle, then re-grant to 0 if it is the only requester.
- Macro undefined: gnt is held for 100 cycles with no timeout.
REQ-036 Reset mid-grant, rst=0 asserted between clock edges while gnt=4'b0010:
- Expect gnt=0, busy=0 immediately.
- After release, expect requester 0 favoured first.

Source files
------------

// File: rtl/fsm_arb_pkg.sv
// Shared types and default constants for the round-robin grant arbiter.
// The optional watchdog is enabled by defining FSM_ARBITER_TIMEOUT_EN.
package fsm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT   = 2'b01,
        RELEASE = 2'b10
    } arb_state_t;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_MAX_HOLD = 16;

    // Wide enough for the largest legal MAX_HOLD (255).
    localparam int HOLD_W = 8;

endpackage

// File: rtl/fsm_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit scanning upward
// from last_id+1 and wrapping from N_REQ-1 back to 0.
module rr_pick
    import fsm_arb_pkg::*;
#(
    parameter  int N_REQ = DEF_N_REQ,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_id,
    output logic [ID_W-1:0]  winner,
    output logic             valid
);

    // cand[k] is the requester that sits k+1 places after last_id.
    logic [ID_W-1:0] cand [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [ID_W:0] sum;
            assign sum = {1'b0, last_id} + (ID_W+1)'(gi + 1);
            assign cand[gi] = (sum >= (ID_W+1)'(N_REQ)) ?
                              ID_W'(sum - (ID_W+1)'(N_REQ)) : sum[ID_W-1:0];
        end
    endgenerate

    // Scan from the farthest candidate down so the nearest one wins.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[cand[k]]) begin
                valid  = 1'b1;
                winner = cand[k];
            end
        end
    end

endmodule

// File: rtl/fsm_arbiter.sv
// Three-state round-robin arbiter (IDLE/GRANT/RELEASE) with registered one-hot grant.
// Define FSM_ARBITER_TIMEOUT_EN to enable the MAX_HOLD watchdog and timeout pulse.
module fsm_arbiter
    import fsm_arb_pkg::*;
#(
    parameter  int N_REQ    = DEF_N_REQ,
    parameter  int MAX_HOLD = DEF_MAX_HOLD,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             timeout
);

    arb_state_t        state_reg,    state_next;
    logic [N_REQ-1:0]  gnt_reg,      gnt_next;
    logic [ID_W-1:0]   gnt_id_reg,   gnt_id_next;
    logic [ID_W-1:0]   last_id_reg,  last_id_next;
    logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
`ifdef FSM_ARBITER_TIMEOUT_EN
    logic              timeout_reg,  timeout_next;
`endif

    logic [ID_W-1:0]   pick_winner;
    logic              pick_valid;
    logic              release_req;
    logic              wd_expire;
    logic              hold_at_max;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req     (req),
        .last_id (last_id_reg),
        .winner  (pick_winner),
        .valid   (pick_valid)
    );

    // Only the current grantee's done/req bits can end a grant.
    assign release_req = done[gnt_id_reg] | ~req[gnt_id_reg];
    assign hold_at_max = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));

`ifdef FSM_ARBITER_TIMEOUT_EN
    assign wd_expire = hold_at_max;
`else
    assign wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            gnt_reg      <= '0;
            gnt_id_reg   <= '0;
            last_id_reg  <= ID_W'(N_REQ - 1);
            hold_cnt_reg <= '0;
`ifdef FSM_ARBITER_TIMEOUT_EN
            timeout_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            gnt_reg      <= gnt_next;
            gnt_id_reg   <= gnt_id_next;
            last_id_reg  <= last_id_next;
            hold_cnt_reg <= hold_cnt_next;
`ifdef FSM_ARBITER_TIMEOUT_EN
            timeout_reg  <= timeout_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        gnt_next      = gnt_reg;
        gnt_id_next   = gnt_id_reg;
        last_id_next  = last_id_reg;
        hold_cnt_next = hold_cnt_reg;
`ifdef FSM_ARBITER_TIMEOUT_EN
        timeout_next  = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next            = GRANT;
                    gnt_next              = '0;
                    gnt_next[pick_winner] = 1'b1;
                    gnt_id_next           = pick_winner;
                    hold_cnt_next         = '0;
                end
            end
            GRANT: begin
                // A genuine release beats the watchdog, so timeout stays low then.
                if (release_req || wd_expire) begin
                    state_next   = RELEASE;
                    gnt_next     = '0;
                    last_id_next = gnt_id_reg;
`ifdef FSM_ARBITER_TIMEOUT_EN
                    timeout_next = ~release_req;
`endif
                end else if (!hold_at_max) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            RELEASE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        gnt     = gnt_reg;
        gnt_id  = gnt_id_reg;
        busy    = (state_reg == GRANT);
`ifdef FSM_ARBITER_TIMEOUT_EN
        timeout = timeout_reg;
`else
        timeout = 1'b0;
`endif
    end

endmodule
